// File: rtl/combo_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : combo_sequencer_if
//  Description : Command / response handshake bundle for combo_sequencer.
//                Command side: cmd_valid/cmd_ready with a 2-bit opcode and a
//                4-bit operand. Response side: rsp_valid/rsp_ready with the
//                echoed opcode, 4-bit result and error flag.
//                master : the requester (issues commands, consumes responses)
//                slave  : the sequencer (accepts commands, returns responses)
//  Revision    : 1.0  initial release
// ============================================================================
interface combo_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_op;
    logic [3:0] rsp_data;
    logic       rsp_err;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_op,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid,
        output rsp_op,
        output rsp_data,
        output rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/combo_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : combo_sequencer
//  Description : Command front-end for the mux/encoder/decoder combo unit.
//                Accepts one operation per command handshake, drives the
//                combo inputs from registers, waits SETTLE_CYCLES, samples
//                the combo outputs and returns them on the response port.
//  Ports       : clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                bus        command/response handshake (slave modport)
//                choice, sel, I0, I1, enc_in, dec_in   registered combo drive
//                mux_out, enc_out, dec_out             combo results
//                op_count   completed responses, wraps at 2^CNT_W
//  Revision    : 1.0  initial release
// ============================================================================
module combo_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    combo_sequencer_if.slave bus,
    output logic [1:0]       choice,
    output logic             sel,
    output logic             I0,
    output logic             I1,
    output logic [3:0]       enc_in,
    output logic [1:0]       dec_in,
    input  logic             mux_out,
    input  logic [1:0]       enc_out,
    input  logic [3:0]       dec_out,
    output logic [CNT_W-1:0] op_count
);

    // Settle counter only has to hold SETTLE_CYCLES-1; keep at least one bit.
    localparam int c_SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_SET_W-1:0] c_SETTLE_LOAD = c_SET_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] c_OP_MUX = 2'b00;
    localparam logic [1:0] c_OP_ENC = 2'b01;
    localparam logic [1:0] c_OP_DEC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_cmd_ready;
    logic               w_accept;
    logic               w_capture;
    logic               w_rsp_done;

    logic [c_SET_W-1:0] r_settle_cnt;
    logic [1:0]         r_choice;
    logic               r_sel;
    logic               r_i0;
    logic               r_i1;
    logic [3:0]         r_enc_in;
    logic [1:0]         r_dec_in;
    logic               r_rsp_valid;
    logic [1:0]         r_rsp_op;
    logic [3:0]         r_rsp_data;
    logic               r_rsp_err;
    logic [CNT_W-1:0]   r_op_count;
    logic [3:0]         w_result;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cmd_ready  = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated by rst_n so the port reads not-ready while reset is held.
                w_cmd_ready = rst_n;
                if (bus.cmd_valid && rst_n) begin
                    w_accept = 1'b1;
                    // Illegal opcode skips the settle window entirely.
                    if (bus.cmd_op == 2'b11) begin
                        w_state_next = ST_RESP;
                    end else begin
                        w_state_next = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (r_settle_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Result selection by the opcode latched at accept time.
    always_comb begin
        w_result = 4'b0000;
        case (r_rsp_op)
            c_OP_MUX: w_result = {3'b000, mux_out};
            c_OP_ENC: w_result = {2'b00, enc_out};
            c_OP_DEC: w_result = dec_out;
            default:  w_result = 4'b0000;
        endcase
    end

    // ------------------------------------------------------------------------
    // Drive registers, settle counter and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_choice     <= 2'b00;
            r_sel        <= 1'b0;
            r_i0         <= 1'b0;
            r_i1         <= 1'b0;
            r_enc_in     <= 4'b0000;
            r_dec_in     <= 2'b00;
            r_rsp_valid  <= 1'b0;
            r_rsp_op     <= 2'b00;
            r_rsp_data   <= 4'b0000;
            r_rsp_err    <= 1'b0;
            r_op_count   <= '0;
        end else begin
            if (w_accept) begin
                r_rsp_op     <= bus.cmd_op;
                r_choice     <= bus.cmd_op;
                r_settle_cnt <= c_SETTLE_LOAD;
                // Only the drive register belonging to the opcode is touched;
                // the others keep their previous values.
                case (bus.cmd_op)
                    c_OP_MUX: begin
                        r_sel <= bus.cmd_data[2];
                        r_i1  <= bus.cmd_data[1];
                        r_i0  <= bus.cmd_data[0];
                    end
                    c_OP_ENC: begin
                        r_enc_in <= bus.cmd_data;
                    end
                    c_OP_DEC: begin
                        r_dec_in <= bus.cmd_data[1:0];
                    end
                    default: begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= 4'b0000;
                        r_rsp_valid <= 1'b1;
                    end
                endcase
            end

            if (r_state == ST_DRIVE) begin
                if (w_capture) begin
                    r_rsp_data  <= w_result;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                end else begin
                    r_settle_cnt <= r_settle_cnt - 1'b1;
                end
            end

            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                r_op_count  <= r_op_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_op    = r_rsp_op;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;

    assign choice   = r_choice;
    assign sel      = r_sel;
    assign I0       = r_i0;
    assign I1       = r_i1;
    assign enc_in   = r_enc_in;
    assign dec_in   = r_dec_in;
    assign op_count = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_combo_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_combo_sequencer
//  Description : Self-checking bench for combo_sequencer. Instance A uses
//                SETTLE_CYCLES=1, CNT_W=2; instance B uses SETTLE_CYCLES=3,
//                CNT_W=8. A behavioural combo unit closes the loop from the
//                drive registers back to the result inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_combo_sequencer;

    localparam int SETTLE_A = 1;
    localparam int CNT_A    = 2;
    localparam int SETTLE_B = 3;
    localparam int CNT_B    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    combo_sequencer_if bus_a ();
    combo_sequencer_if bus_b ();

    logic [1:0]       choice_a, dec_in_a, enc_out_a, choice_b, dec_in_b, enc_out_b;
    logic             sel_a, i0_a, i1_a, mux_out_a, sel_b, i0_b, i1_b, mux_out_b;
    logic [3:0]       enc_in_a, dec_out_a, enc_in_b, dec_out_b;
    logic [CNT_A-1:0] op_count_a;
    logic [CNT_B-1:0] op_count_b;

    combo_sequencer #(.SETTLE_CYCLES(SETTLE_A), .CNT_W(CNT_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .choice(choice_a), .sel(sel_a), .I0(i0_a), .I1(i1_a),
        .enc_in(enc_in_a), .dec_in(dec_in_a),
        .mux_out(mux_out_a), .enc_out(enc_out_a), .dec_out(dec_out_a),
        .op_count(op_count_a)
    );

    combo_sequencer #(.SETTLE_CYCLES(SETTLE_B), .CNT_W(CNT_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .choice(choice_b), .sel(sel_b), .I0(i0_b), .I1(i1_b),
        .enc_in(enc_in_b), .dec_in(dec_in_b),
        .mux_out(mux_out_b), .enc_out(enc_out_b), .dec_out(dec_out_b),
        .op_count(op_count_b)
    );

    // Behavioural combo unit: 2:1 mux, 4:2 priority encoder, 2:4 decoder.
    function automatic logic [1:0] combo_enc(input logic [3:0] v);
        casez (v)
            4'b1???: return 2'd3;
            4'b01??: return 2'd2;
            4'b001?: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    always_comb begin
        mux_out_a = sel_a ? i1_a : i0_a;
        enc_out_a = combo_enc(enc_in_a);
        dec_out_a = 4'b0001 << dec_in_a;
        mux_out_b = sel_b ? i1_b : i0_b;
        enc_out_b = combo_enc(enc_in_b);
        dec_out_b = 4'b0001 << dec_in_b;
    end

    // Reference result computed straight from the operation definitions.
    function automatic logic [3:0] ref_result(input logic [1:0] op, input logic [3:0] d);
        logic [3:0] r;
        r = 4'd0;
        case (op)
            2'd0: r = d[2] ? {3'b000, d[1]} : {3'b000, d[0]};
            2'd1: for (int i = 0; i < 4; i++) if (d[i]) r = 4'(i);
            2'd2: r = 4'(1 << int'(d[1:0]));
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of instance A drive registers and counter.
    logic [1:0] m_choice, m_dec;
    logic       m_sel, m_i0, m_i1;
    logic [3:0] m_enc;
    int         m_count_a = 0;
    int         m_count_b = 0;

    task automatic model_reset();
        m_choice = 2'd0; m_sel = 1'b0; m_i0 = 1'b0; m_i1 = 1'b0;
        m_enc = 4'd0; m_dec = 2'd0;
        m_count_a = 0; m_count_b = 0;
    endtask

    task automatic model_drive(input logic [1:0] op, input logic [3:0] d);
        m_choice = op;
        if (op == 2'd0) {m_sel, m_i1, m_i0} = d[2:0];
        else if (op == 2'd1) m_enc = d;
        else if (op == 2'd2) m_dec = d[1:0];
    endtask

    function automatic logic [10:0] drive_a();
        return {choice_a, sel_a, i1_a, i0_a, enc_in_a, dec_in_a};
    endfunction

    function automatic logic [10:0] drive_model();
        return {m_choice, m_sel, m_i1, m_i0, m_enc, m_dec};
    endfunction

    // One complete transaction on instance A with full checking.
    task automatic run_a(input logic [1:0] op, input logic [3:0] d,
                         input logic [3:0] exp_data, input logic exp_err, input int hold);
        int waited;
        int lat;
        waited = 0;
        while (!bus_a.cmd_ready && waited < 10) begin tick(); waited++; end
        check("a_cmd_ready_before", 32'(bus_a.cmd_ready), 32'd1);
        bus_a.rsp_ready = 1'($urandom);   // ignored outside the response state
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_op    = op;
        bus_a.cmd_data  = d;
        tick();
        bus_a.cmd_valid = 1'b0;
        bus_a.cmd_op    = 2'($urandom);
        bus_a.cmd_data  = 4'($urandom);
        model_drive(op, d);
        lat = 1;
        while (!bus_a.rsp_valid && lat < 20) begin
            bus_a.rsp_ready = 1'($urandom);
            tick();
            lat++;
        end
        bus_a.rsp_ready = 1'b0;
        check("a_latency", 32'(lat), (op == 2'd3) ? 32'd1 : 32'(SETTLE_A + 1));
        check("a_drive_regs", 32'(drive_a()), 32'(drive_model()));
        check("a_rsp_op", 32'(bus_a.rsp_op), 32'(op));
        check("a_rsp_data", 32'(bus_a.rsp_data), 32'(exp_data));
        check("a_rsp_err", 32'(bus_a.rsp_err), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("a_hold_stable",
                  32'({bus_a.rsp_valid, bus_a.rsp_op, bus_a.rsp_data, bus_a.rsp_err,
                       bus_a.cmd_ready, op_count_a}),
                  32'({1'b1, op, exp_data, exp_err, 1'b0, CNT_A'(m_count_a)}));
        end
        bus_a.rsp_ready = 1'b1;
        tick();
        bus_a.rsp_ready = 1'b0;
        m_count_a = (m_count_a + 1) % (1 << CNT_A);
        check("a_after_handshake",
              32'({bus_a.rsp_valid, bus_a.cmd_ready, op_count_a}),
              32'({1'b0, 1'b1, CNT_A'(m_count_a)}));
    endtask

    // Transaction on instance B: latency, result and counter.
    task automatic run_b(input logic [1:0] op, input logic [3:0] d);
        int waited;
        int lat;
        waited = 0;
        while (!bus_b.cmd_ready && waited < 10) begin tick(); waited++; end
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_op    = op;
        bus_b.cmd_data  = d;
        tick();
        bus_b.cmd_valid = 1'b0;
        lat = 1;
        while (!bus_b.rsp_valid && lat < 20) begin tick(); lat++; end
        check("b_latency", 32'(lat), (op == 2'd3) ? 32'd1 : 32'(SETTLE_B + 1));
        check("b_rsp", 32'({bus_b.rsp_op, bus_b.rsp_data, bus_b.rsp_err}),
              32'({op, ref_result(op, d), op == 2'd3}));
        bus_b.rsp_ready = 1'b1;
        tick();
        bus_b.rsp_ready = 1'b0;
        m_count_b = m_count_b + 1;
        check("b_op_count", 32'(op_count_b), 32'(m_count_b));
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        int         hold;
        logic [3:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'b00, 4'b0110, 0, 4'b0001, 1'b0};
        vecs[1] = '{2'b01, 4'b1000, 0, 4'b0011, 1'b0};
        vecs[2] = '{2'b10, 4'b0010, 5, 4'b0100, 1'b0};
        vecs[3] = '{2'b11, 4'b0101, 0, 4'b0000, 1'b1};
        vecs[4] = '{2'b00, 4'b0001, 1, 4'b0001, 1'b0};
        vecs[5] = '{2'b01, 4'b0010, 0, 4'b0001, 1'b0};
        vecs[6] = '{2'b10, 4'b0011, 2, 4'b1000, 1'b0};

        bus_a.cmd_valid = 1'b0; bus_a.cmd_op = 2'd0; bus_a.cmd_data = 4'd0; bus_a.rsp_ready = 1'b0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_op = 2'd0; bus_b.cmd_data = 4'd0; bus_b.rsp_ready = 1'b0;
        model_reset();

        // Reset state while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({bus_a.cmd_ready, bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_data, op_count_a}),
              32'd0);
        check("reset_drive", 32'(drive_a()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(bus_a.cmd_ready), 32'd1);

        // Directed vectors.
        for (int v = 0; v < 7; v++) begin
            run_a(vecs[v].op, vecs[v].data, vecs[v].exp_data, vecs[v].exp_err, vecs[v].hold);
        end

        // Back-to-back operations with the response always accepted.
        bus_a.rsp_ready = 1'b1;
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_op    = 2'b00;
        bus_a.cmd_data  = 4'b0110;
        model_drive(2'b00, 4'b0110);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k % 3 == 0) m_count_a = (m_count_a + 1) % (1 << CNT_A);
            check("b2b_cmd_ready", 32'(bus_a.cmd_ready), (k % 3 == 0) ? 32'd1 : 32'd0);
            check("b2b_op_count", 32'(op_count_a), 32'(m_count_a));
            if (k % 3 == 2)
                check("b2b_rsp", 32'({bus_a.rsp_valid, bus_a.rsp_data}), 32'({1'b1, 4'b0001}));
        end
        bus_a.cmd_valid = 1'b0;
        bus_a.rsp_ready = 1'b0;

        // Reset asserted while an operation is in its settle window.
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_op    = 2'b01;
        bus_a.cmd_data  = 4'b0100;
        tick();
        bus_a.cmd_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midop_reset",
              32'({bus_a.rsp_valid, choice_a, op_count_a, bus_a.cmd_ready}), 32'd0);
        check("midop_reset_drive", 32'(drive_a()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("after_release_idle", 32'({bus_a.rsp_valid, bus_a.cmd_ready}), 32'({1'b0, 1'b1}));
        run_a(2'b01, 4'b0100, 4'b0010, 1'b0, 0);

        // Randomized operations against the reference model.
        for (int r = 0; r < 40; r++) begin
            logic [1:0] op;
            logic [3:0] d;
            op = 2'($urandom_range(0, 3));
            d  = 4'($urandom);
            run_a(op, d, ref_result(op, d), op == 2'd3, int'($urandom_range(0, 2)));
        end

        // Longer settle window on instance B.
        run_b(2'b00, 4'b0101);
        run_b(2'b01, 4'b0110);
        run_b(2'b11, 4'b1111);
        for (int r = 0; r < 6; r++) run_b(2'($urandom_range(0, 3)), 4'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
